// File: rtl/image_loader.sv
// Frame buffer in front of conv1: loads one image over a valid/ready byte
// port, streams it gap-free, then waits for the classifier's decision.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_valid/wr_data    pixel write offer (raster order)
//   wr_ready            buffer accepting pixels (LOAD only)
//   data_out/valid_out  registered pixel stream to conv1 (0 when idle)
//   done_in/decision_in classifier handshake
//   result/result_valid captured class, one-cycle update pulse
//   busy                state is STREAM or WAIT
//   timeout             last frame ended by the watchdog
//
// Optional: define IMG_WATCHDOG_EN to bound the WAIT state by
// TIMEOUT_CYCLES; otherwise WAIT holds until done_in and timeout is 0.

module image_loader #(
  parameter int unsigned IMG_PIXELS     = 784,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 done_in,
  input  logic [3:0]           decision_in,
  output logic [3:0]           result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 timeout
);

  if ((2 ** ADDR_BITS) < IMG_PIXELS || IMG_PIXELS < 2 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("image_loader: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_LOAD,
    S_STREAM,
    S_WAIT
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(IMG_PIXELS - 1);

  state_e                 state_q;
  logic [ADDR_BITS-1:0]   wr_addr_q;
  logic [ADDR_BITS-1:0]   rd_addr_q;
  logic [DATA_BITS-1:0]   mem [0:IMG_PIXELS-1];
  logic [DATA_BITS-1:0]   rd_data_q;
  logic                   rd_vld_q;
  logic                   wr_ready_q;
  logic [DATA_BITS-1:0]   data_out_q;
  logic                   valid_out_q;
  logic [3:0]             result_q;
  logic                   result_valid_q;
  logic                   busy_q;
  logic                   accept;
  logic                   rd_en;

`ifdef IMG_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]            wd_q;
  logic                   timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // wr_ready_q is only ever high in LOAD, so it alone gates writes
  assign accept = wr_valid & wr_ready_q;
  assign rd_en  = (state_q == S_STREAM);

  // Buffer: no reset so it maps onto block RAM; read is synchronous
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr_q] <= wr_data;
    if (rd_en)  rd_data_q <= mem[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_LOAD;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      rd_vld_q       <= 1'b0;
      wr_ready_q     <= 1'b1;
      data_out_q     <= '0;
      valid_out_q    <= 1'b0;
      result_q       <= 4'h0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef IMG_WATCHDOG_EN
      wd_q           <= 16'h0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      result_valid_q <= 1'b0;
      // Two-stage read pipe: RAM register, then output register
      rd_vld_q       <= rd_en;
      valid_out_q    <= rd_vld_q;
      data_out_q     <= rd_vld_q ? rd_data_q : '0;

      unique case (state_q)
        S_LOAD: begin
          wr_ready_q <= 1'b1;
          if (accept) begin
            if (wr_addr_q == LAST) begin
              wr_addr_q  <= '0;
              wr_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_STREAM;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end

        S_STREAM: begin
          wr_ready_q <= 1'b0;
          if (rd_addr_q == LAST) begin
            rd_addr_q <= '0;
            // a decision arriving on the WAIT entry edge is not lost
            if (done_in) begin
              result_q       <= decision_in;
              result_valid_q <= 1'b1;
              busy_q         <= 1'b0;
              state_q        <= S_LOAD;
`ifdef IMG_WATCHDOG_EN
              timeout_q      <= 1'b0;
`endif
            end else begin
              state_q <= S_WAIT;
`ifdef IMG_WATCHDOG_EN
              wd_q    <= 16'h0;
`endif
            end
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end

        S_WAIT: begin
          wr_ready_q <= 1'b0;
          if (done_in) begin
            result_q       <= decision_in;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_LOAD;
`ifdef IMG_WATCHDOG_EN
            timeout_q      <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            result_q       <= 4'hF;
            result_valid_q <= 1'b1;
            timeout_q      <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_LOAD;
          end else begin
            wd_q <= wd_q + 16'h1;
`endif
          end
        end

        default: begin
          state_q <= S_LOAD;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready     = wr_ready_q;
  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

endmodule

// File: doc/image_loader.md
# image_loader

Synthesizable front end of the MNIST CNN datapath: buffers one 28x28 8-bit image written over a valid/ready byte port, then streams it one pixel per clock into `conv1_layer.data_in`. It then waits for the classification from `comparator` and reports it before accepting the next image. It replaces the simulation-only pixel array in the top level and sits directly upstream of `conv1_layer`.

## Interface
- `IMG_PIXELS`, 784, pixels per frame (≥2)
- `DATA_BITS`, 8, pixel width
- `ADDR_BITS`, 10, buffer address width (2^ADDR_BITS ≥ IMG_PIXELS)
- `TIMEOUT_CYCLES`, 4096, watchdog limit in WAIT (used only with `IMG_WATCHDOG_EN`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `wr_valid` in 1: write pixel offered
- `wr_data` in DATA_BITS: pixel value, raster order
- `wr_ready` out 1: buffer accepting pixels
- `data_out` out DATA_BITS: pixel to `conv1_layer.data_in`
- `valid_out` out 1: `data_out` carries a frame pixel
- `done_in` in 1: `comparator.valid_out`
- `decision_in` in 4: `comparator.decision`
- `result` out 4: captured classification
- `result_valid` out 1: one-cycle pulse, `result` updated
- `busy` out 1: high in STREAM or WAIT
- `timeout` out 1: last frame ended by watchdog

## Operation
- FSM states: LOAD → STREAM → WAIT → LOAD.
- LOAD: `wr_ready`=1. Accept when `wr_valid & wr_ready`. Write `wr_data` to `mem[wr_addr]`, then increment `wr_addr`. Accepting pixel IMG_PIXELS-1 clears `wr_addr` and moves to STREAM next cycle.
- STREAM: `wr_ready`=0. `rd_addr` counts 0..IMG_PIXELS-1, one per cycle. Memory read is synchronous; `data_out`/`valid_out` are registered. Output is exactly IMG_PIXELS consecutive valid cycles, gap-free, in raster order. When the last address is issued, the state goes to WAIT; the final pixel appears the next cycle.
- WAIT: `wr_ready`=0. On `done_in`=1, register `result`←`decision_in`, pulse `result_valid` for 1 cycle, clear `timeout`, go to LOAD.
- `data_out`=0 whenever `valid_out`=0. conv1 runs free, so idle input is zero.
- `done_in` in LOAD/STREAM: ignored. `wr_valid` outside LOAD: ignored, no data lost (ready low).
- `busy` = (state≠LOAD), registered with the state.
- Reset (any time, incl. mid-STREAM): state LOAD, counters 0, outputs to reset values. Buffer contents are not cleared and are fully overwritten by the next load.

## Timing
- Reset values: `wr_ready`=1, `data_out`=0, `valid_out`=0, `result`=0, `result_valid`=0, `busy`=0, `timeout`=0.
- Last write accepted at edge N → state STREAM after N. First `valid_out` after edge N+2. Last `valid_out` after edge N+IMG_PIXELS+1.
- Max load throughput is 1 pixel/cycle. Back-pressure is only by state.
- `done_in` at edge M (in WAIT) → `result_valid`=1 and `result` valid after M. `wr_ready`=1 after M+1.
- `done_in` on the same edge WAIT is entered is honoured.

## Configuration
- `IMG_WATCHDOG_EN` defined:
  - A 16-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without `done_in`, then `result`←4'hF, `result_valid` pulses, `timeout`←1, and the state goes to LOAD.
  - If `done_in` and expiry occur on the same cycle, `done_in` wins.
- Not defined: no counter. WAIT holds until `done_in` or reset, and `timeout` is tied 0.

## Test plan
- Load a ramp (pixel i = i mod 256) with `wr_valid` held high → `wr_ready` drops after 784 accepts. `valid_out` is high for exactly 784 cycles, starting 2 cycles after the last accept, with `data_out` = 0,1,…,255,0,…,15.
- Load with `wr_valid` toggling every other cycle, and again with random gaps → the streamed sequence equals the written sequence. Extra `wr_valid` pulses during STREAM/WAIT are not accepted.
- Drive `done_in`=1 with `decision_in`=7 during STREAM, then again in WAIT → the first is ignored. The second gives `result`=7 and a 1-cycle `result_valid`, and `wr_ready`=1 two edges later.
- Assert `rst_n`=0 asynchronously mid-STREAM at pixel 300 → outputs go to reset values immediately and the state is LOAD. A fresh 784-pixel load then streams correctly from pixel 0.
- With `IMG_WATCHDOG_EN` and TIMEOUT_CYCLES=16, never assert `done_in` → after 16 WAIT cycles `result`=4'hF, `timeout`=1, and `result_valid` pulses. The next frame with `done_in` and `decision_in`=3 clears `timeout` to 0.
- Without the macro, hold WAIT for 10000 cycles → no `result_valid` and `busy` stays 1.
